uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameters SHALL be as follows.
- DATA_WIDTH, default 8: entry width in bits.
- ADDR_WIDTH, default 4: log2 of the depth, so DEPTH = 16 by default.
- AFULL_LEVEL, default 12: threshold count for the almost-full flag.

REQ-002 Ports SHALL be as follows.
- clk, input, 1: system clock. All logic runs on its rising edge.
- reset_n, input, 1: reset, asynchronous, active-low.
- wdata, input, DATA_WIDTH: byte written by the host.
- we_n, input, 1: write request, active-low, one entry per low cycle.
- re_n, input, 1: read request, active-low, one entry per low cycle. Driven by the transmitter's fifo_read_tx.
- flush, input, 1: synchronous clear, active-high.
- dout, output, DATA_WIDTH: registered read data. Drives the transmitter's tx_dout_reg.
- empty, output, 1: high when count==0. Drives the transmitter's fifo_empty.
- full, output, 1: high when count==DEPTH. Drives the transmitter's fifo_full.
- afull, output, 1: high when count>=AFULL_LEVEL.
- count, output, ADDR_WIDTH+1: number of stored entries, 0..DEPTH.
- overflow, output, 1: one-cycle pulse on a rejected write.
- underflow, output, 1: one-cycle pulse on a rejected read.

Function
REQ-003 Storage SHALL be a DEPTH x DATA_WIDTH memory addressed by ADDR_WIDTH-bit write and read pointers that wrap modulo DEPTH.

REQ-004 A write SHALL be accepted when we_n=0 and either full=0, or full=1 with an accepted read in the same cycle. An accepted write stores wdata at wr_ptr and increments wr_ptr.

REQ-005 A read SHALL be accepted when re_n=0 and empty=0. An accepted read loads dout with mem[rd_ptr] at that clock edge and increments rd_ptr.

REQ-006 Read latency SHALL be one cycle: dout carries the entry on the cycle after re_n is sampled low. dout holds that value until the next accepted read.

REQ-007 The FIFO SHALL NOT provide fall-through. When empty=1 and we_n=0, re_n=0 occur together, the write is accepted, the read is rejected, and underflow pulses.

REQ-008 When full=1 and both we_n=0 and re_n=0, both operations SHALL be accepted and count SHALL stay at DEPTH.

REQ-009 count SHALL be updated as follows:
- +1 for a write alone;
- -1 for a read alone;
- unchanged when both or neither are accepted.

It SHALL never exceed DEPTH and never wrap below 0.

REQ-010 empty, full and afull SHALL be decoded from the registered count. They therefore reflect an operation on the cycle after it is sampled.

REQ-011 overflow SHALL pulse high for exactly one cycle when we_n=0, full=1 and no read is accepted. The data is discarded and the pointers are unchanged.

REQ-012 underflow SHALL pulse high for exactly one cycle when re_n=0 and empty=1. dout and the pointers are unchanged.

REQ-013 flush=1 SHALL take priority over any same-cycle read or write, and SHALL set:
- wr_ptr=0, rd_ptr=0 and count=0;
- dout=0;
- overflow and underflow low.

Memory contents are don't-care.

REQ-014 Pointer wrap from DEPTH-1 to 0 SHALL be seamless. Data order is preserved across any number of wraps.

REQ-015 Memory contents SHALL NOT be reset. No memory location is readable before it has been written.

Reset
REQ-016 While reset_n=0, asynchronously and regardless of clk, the block SHALL hold:
- wr_ptr=0, rd_ptr=0 and count=0;
- dout=0;
- empty=1, full=0 and afull=0;
- overflow=0 and underflow=0.

REQ-017 Reset asserted mid-operation SHALL discard all stored entries. The first accepted write after reset_n rises lands at address 0.

REQ-018 No read or write SHALL be accepted on the clock edge at which reset_n is low.

Verification
REQ-019 Reset check: assert reset_n=0 while count=5 -> within the same cycle count=0, empty=1, full=0 and dout=0. After release, write 0x3C then read -> dout=0x3C one cycle after the read.

REQ-020 Fill and overflow: write 0x00..0x0F (16 writes) -> full=1 and count=16, with afull=1 from count 12 onward. A 17th write of 0xAA -> overflow pulses for one cycle, count stays 16, and 0xAA is never read out.

REQ-021 Order and wrap: perform 40 interleaved writes and reads with random gaps, keeping count<=16 -> dout sequence equals the write sequence exactly, and pointers wrap twice.

REQ-022 Simultaneous operations:
- At full, we_n=0 and re_n=0 together -> count stays 16, and dout = oldest entry.
- At empty, we_n=0 and re_n=0 together -> count=1, underflow pulses, dout unchanged.

REQ-023 Transmitter handshake: with 3 entries loaded, drive re_n as a single low cycle followed by two high cycles (the transmitter's idle/delay/load sequence) -> dout is valid by the start-bit cycle, and empty rises only after the third read.

REQ-024 Flush: with count=7 and we_n=0 in the same cycle as flush=1 -> the next cycle shows count=0, empty=1 and dout=0, and the written byte is dropped.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous transmit FIFO feeding the UART transmitter.
// Registered read data, no fall-through, overflow/underflow pulses.
module uart_tx_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  we_n,
  input  logic                  re_n,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  full,
  output logic                  afull,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C =
    (ADDR_WIDTH+1)'(AFULL_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  rd_ok;
  logic                  wr_ok;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);
  assign afull = (count >= AFULL_C);

  // A write into a full FIFO is only legal
  // when a read frees a slot on the same edge.
  assign rd_ok = !re_n && !empty;
  assign wr_ok = !we_n && (!full || rd_ok);

  // Storage array; contents are never cleared.
  always_ff @(posedge clk) begin
    if (reset_n && !flush && wr_ok)
      mem[wr_ptr] <= wdata;
  end

  // Pointers, occupancy, read data and error pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      dout      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      dout      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= !we_n && full && !rd_ok;
      underflow <= !re_n && empty;
      if (wr_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout   <= mem[rd_ptr];
      end
      unique case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: vector table plus queue scoreboard
// for the transmit FIFO.
module tb_uart_tx_fifo;

  logic       clk;
  logic       reset_n;
  logic [7:0] wdata;
  logic       we_n;
  logic       re_n;
  logic       flush;
  logic [7:0] dout;
  logic       empty;
  logic       full;
  logic       afull;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  uart_tx_fifo #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .AFULL_LEVEL(12)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .wdata(wdata),
    .we_n(we_n),
    .re_n(re_n),
    .flush(flush),
    .dout(dout),
    .empty(empty),
    .full(full),
    .afull(afull),
    .count(count),
    .overflow(overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] q[$];
  int         mcount;
  logic [7:0] mdout;
  logic       eov;
  logic       eun;

  typedef struct {
    logic       w;
    logic       r;
    logic [7:0] d;
    logic       fl;
    int         cnt;
    logic [7:0] dq;
    logic       ov;
    logic       un;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm,
                     input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mcount = 0;
    mdout  = 8'h00;
    eov    = 1'b0;
    eun    = 1'b0;
  endtask

  // One clock: predict, drive, clock, compare.
  task automatic cyc(input logic w, input logic r,
                     input logic [7:0] d, input logic fl);
    logic rd;
    logic wr;
    int   old;
    old = mcount;
    rd  = !r && (old != 0);
    wr  = !w && ((old != 16) || rd);
    we_n  = w;
    re_n  = r;
    wdata = d;
    flush = fl;
    @(posedge clk);
    #1;
    if (fl) begin
      model_reset();
    end else begin
      if (rd) mdout = q.pop_front();
      if (wr) q.push_back(d);
      mcount = old + (wr ? 1 : 0) - (rd ? 1 : 0);
      eov = !w && (old == 16) && !rd;
      eun = !r && (old == 0);
    end
    we_n  = 1'b1;
    re_n  = 1'b1;
    flush = 1'b0;
    chk("count", int'(count), mcount);
    chk("empty", int'(empty), int'(mcount == 0));
    chk("full", int'(full), int'(mcount == 16));
    chk("afull", int'(afull), int'(mcount >= 12));
    chk("overflow", int'(overflow), int'(eov));
    chk("underflow", int'(underflow), int'(eun));
    chk("dout", int'(dout), int'(mdout));
  endtask

  logic [7:0] hs[3];
  int nw;
  int cyc_n;

  initial begin
    vt[0] = '{1'b0, 1'b1, 8'h11, 1'b0, 1, 8'h00, 1'b0, 1'b0};
    vt[1] = '{1'b0, 1'b1, 8'h22, 1'b0, 2, 8'h00, 1'b0, 1'b0};
    vt[2] = '{1'b1, 1'b0, 8'h00, 1'b0, 1, 8'h11, 1'b0, 1'b0};
    vt[3] = '{1'b0, 1'b0, 8'h33, 1'b0, 1, 8'h22, 1'b0, 1'b0};
    vt[4] = '{1'b1, 1'b0, 8'h00, 1'b0, 0, 8'h33, 1'b0, 1'b0};
    vt[5] = '{1'b1, 1'b0, 8'h00, 1'b0, 0, 8'h33, 1'b0, 1'b1};
    vt[6] = '{1'b0, 1'b0, 8'h44, 1'b0, 1, 8'h33, 1'b0, 1'b1};
    vt[7] = '{1'b1, 1'b1, 8'h00, 1'b0, 1, 8'h33, 1'b0, 1'b0};
    vt[8] = '{1'b1, 1'b0, 8'h00, 1'b0, 0, 8'h44, 1'b0, 1'b0};
    vt[9] = '{1'b0, 1'b1, 8'h55, 1'b1, 0, 8'h00, 1'b0, 1'b0};

    reset_n = 1'b0;
    we_n    = 1'b1;
    re_n    = 1'b1;
    flush   = 1'b0;
    wdata   = 8'h00;
    model_reset();

    #3;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_afull", int'(afull), 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_unf", int'(underflow), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Vector table from a clean FIFO.
    for (int i = 0; i < 10; i++) begin
      cyc(vt[i].w, vt[i].r, vt[i].d, vt[i].fl);
      chk($sformatf("vec%0d_count", i), int'(count), vt[i].cnt);
      chk($sformatf("vec%0d_dout", i), int'(dout), int'(vt[i].dq));
      chk($sformatf("vec%0d_ovf", i), int'(overflow), int'(vt[i].ov));
      chk($sformatf("vec%0d_unf", i), int'(underflow), int'(vt[i].un));
    end

    // Asynchronous reset with five entries stored.
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'(8'h60 + i), 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'h65, 1'b0);
    chk("pre_rst_count", int'(count), 5);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_count", int'(count), 0);
    chk("arst_empty", int'(empty), 1);
    chk("arst_full", int'(full), 0);
    chk("arst_dout", int'(dout), 0);
    we_n  = 1'b0;
    re_n  = 1'b0;
    wdata = 8'hEE;
    @(posedge clk);
    #1;
    we_n = 1'b1;
    re_n = 1'b1;
    chk("in_rst_count", int'(count), 0);
    reset_n = 1'b1;
    model_reset();
    cyc(1'b0, 1'b1, 8'h3C, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    chk("post_rst_dout", int'(dout), 8'h3C);
    chk("post_rst_addr0", int'(dut.mem[0]), 8'h3C);

    // Fill to full, then overflow.
    for (int k = 0; k < 16; k++) begin
      cyc(1'b0, 1'b1, 8'(k), 1'b0);
      chk("fill_afull", int'(afull), int'(k + 1 >= 12));
    end
    chk("fill_full", int'(full), 1);
    chk("fill_count", int'(count), 16);
    cyc(1'b0, 1'b1, 8'hAA, 1'b0);
    chk("ovf_pulse", int'(overflow), 1);
    chk("ovf_count", int'(count), 16);
    cyc(1'b1, 1'b1, 8'h00, 1'b0);
    chk("ovf_clear", int'(overflow), 0);

    // Read and write together while full.
    cyc(1'b0, 1'b0, 8'h55, 1'b0);
    chk("full_rw_count", int'(count), 16);
    chk("full_rw_dout", int'(dout), 8'h00);
    for (int k = 1; k < 17; k++) begin
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      chk("drain_dout", int'(dout), (k == 16) ? 8'h55 : k);
    end
    chk("drain_empty", int'(empty), 1);

    // Read and write together while empty.
    cyc(1'b0, 1'b0, 8'h77, 1'b0);
    chk("empty_rw_count", int'(count), 1);
    chk("empty_rw_unf", int'(underflow), 1);
    chk("empty_rw_dout", int'(dout), 8'h55);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    chk("empty_rw_read", int'(dout), 8'h77);

    // Random interleaving, 40 writes through the scoreboard.
    nw    = 0;
    cyc_n = 0;
    while (!(nw == 40 && mcount == 0) && cyc_n < 2000) begin
      logic w;
      logic r;
      w = !((nw < 40) && (mcount < 16) &&
            ($urandom_range(0, 2) != 0));
      r = !((mcount > 0) && ($urandom_range(0, 2) != 0));
      if (!w) nw++;
      cyc(w, r, 8'($urandom), 1'b0);
      cyc_n++;
    end
    chk("rand_done", int'(cyc_n < 2000), 1);
    chk("rand_empty", int'(empty), 1);

    // Transmitter read cadence: one low, two high.
    hs[0] = 8'hA1;
    hs[1] = 8'hA2;
    hs[2] = 8'hA3;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, hs[i], 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      chk("tx_dout", int'(dout), int'(hs[i]));
      chk("tx_empty", int'(empty), int'(i == 2));
      cyc(1'b1, 1'b1, 8'h00, 1'b0);
      chk("tx_hold", int'(dout), int'(hs[i]));
      cyc(1'b1, 1'b1, 8'h00, 1'b0);
    end

    // Flush with a concurrent write.
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 8'(8'h90 + i), 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'h97, 1'b0);
    chk("pre_flush_count", int'(count), 7);
    cyc(1'b0, 1'b1, 8'h99, 1'b1);
    chk("flush_count", int'(count), 0);
    chk("flush_empty", int'(empty), 1);
    chk("flush_dout", int'(dout), 0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    chk("flush_unf", int'(underflow), 1);
    cyc(1'b0, 1'b1, 8'h5A, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    chk("flush_next", int'(dout), 8'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
